// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//
// Programmable-window up/down/bounce counter with a prescaler. The count
// moves inside [cfg_min, cfg_max] (inclusive), one step every presc+1
// enabled cycles. At the window edges it either wraps or saturates.
// Bounce mode ping-pongs between the edges. Hold mode freezes the count and
// the prescaler.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   en        in   count enable (gates prescaler and stepping)
//   clear     in   count <= cfg_min, dir <= up, prescaler restarts
//   load      in   count <= load_val (no range check), prescaler restarts
//   load_val  in   [WIDTH]   value for load
//   mode      in   [2]       00 up, 01 down, 10 bounce, 11 hold
//   sat       in   1 = saturate at edges, 0 = wrap (ignored in bounce)
//   cfg_min   in   [WIDTH]   lower bound, inclusive
//   cfg_max   in   [WIDTH]   upper bound, inclusive
//   presc     in   [PRESC_W] cycles per step minus one
//   count     out  [WIDTH]   current count
//   dir       out  current direction, 0 up / 1 down
//   tc        out  pulse: the step result equals the terminal value
//   wrap      out  pulse: wrap, saturate block, bounce turn or range recovery
//   err       out  high while cfg_min > cfg_max; stepping is suppressed
// ---------------------------------------------------------------------------
module updown_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [1:0]         mode,
    input  logic               sat,
    input  logic [WIDTH-1:0]   cfg_min,
    input  logic [WIDTH-1:0]   cfg_max,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               tc,
    output logic               wrap,
    output logic               err
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
    localparam logic [PRESC_W-1:0] ONE_P = PRESC_W'(1);

    mode_e              mode_s;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic               tc_q, tc_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;

    logic               presc_run;
    logic               step_fire;
    logic               out_of_range;
    logic [WIDTH-1:0]   step_count;
    logic               step_dir;
    logic               step_wrap;

    assign mode_s = mode_e'(mode);

    // The prescaler only advances when a step could actually be taken.
    assign presc_run = en && (mode_s != MODE_HOLD) && !err_q;
    assign step_fire = presc_run && (pcnt_q == presc);

    // Full-width compares: no arithmetic is done on an out-of-window count,
    // so +1 / -1 below can never overflow or underflow.
    assign out_of_range = (count_q < cfg_min) || (count_q > cfg_max);

    // Result of a step, computed unconditionally; only committed when a
    // step fires and nothing of higher priority is active.
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        step_count = count_q;
        step_dir   = dir_q;
        step_wrap  = 1'b0;
        unique case (mode_s)
            MODE_UP: begin
                step_dir = 1'b0;
                if (out_of_range) begin
                    step_count = cfg_min;
                    step_wrap  = 1'b1;
                end else if (count_q == cfg_max) begin
                    step_count = sat ? cfg_max : cfg_min;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = count_q + ONE_W;
                end
            end
            MODE_DOWN: begin
                step_dir = 1'b1;
                if (out_of_range) begin
                    step_count = cfg_max;
                    step_wrap  = 1'b1;
                end else if (count_q == cfg_min) begin
                    step_count = sat ? cfg_min : cfg_max;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = count_q - ONE_W;
                end
            end
            MODE_BOUNCE: begin
                if (out_of_range) begin
                    step_count = cfg_min;
                    step_dir   = 1'b0;
                    step_wrap  = 1'b1;
                end else if (cfg_min == cfg_max) begin
                    // Degenerate window: nowhere to go, report a turn.
                    step_wrap  = 1'b1;
                end else if (!dir_q && (count_q == cfg_max)) begin
                    step_count = cfg_max - ONE_W;
                    step_dir   = 1'b1;
                    step_wrap  = 1'b1;
                end else if (dir_q && (count_q == cfg_min)) begin
                    step_count = cfg_min + ONE_W;
                    step_dir   = 1'b0;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = dir_q ? (count_q - ONE_W) : (count_q + ONE_W);
                end
            end
            default: begin
                // MODE_HOLD never fires a step; defaults keep everything.
            end
        endcase
    end

    // Next-state selection with priority clear > load > step.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        pcnt_d  = pcnt_q;
        tc_d    = 1'b0;
        wrap_d  = 1'b0;
        err_d   = (cfg_min > cfg_max);

        if (clear) begin
            count_d = cfg_min;
            dir_d   = 1'b0;
            pcnt_d  = '0;
        end else if (load) begin
            count_d = load_val;
            pcnt_d  = '0;
        end else if (presc_run) begin
            if (step_fire) begin
                pcnt_d  = '0;
                count_d = step_count;
                dir_d   = step_dir;
                wrap_d  = step_wrap;
                // Terminal value follows the post-step direction.
                tc_d    = (step_count == (step_dir ? cfg_min : cfg_max));
            end else begin
                pcnt_d  = pcnt_q + ONE_P;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            tc_q    <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign tc    = tc_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Directed bench for updown_mod_counter (WIDTH=4, PRESC_W=4). Inputs change
// 1 ns after the rising edge and outputs are sampled at the same point, so
// every sample reflects the edge just taken. Expected values are written
// out by hand for each step.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 4;

    logic               clk;
    logic               reset;
    logic               en;
    logic               clear;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [1:0]         mode;
    logic               sat;
    logic [WIDTH-1:0]   cfg_min;
    logic [WIDTH-1:0]   cfg_max;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   count;
    logic               dir;
    logic               tc;
    logic               wrap;
    logic               err;

    int checks = 0;
    int errors = 0;

    updown_mod_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .sat      (sat),
        .cfg_min  (cfg_min),
        .cfg_max  (cfg_max),
        .presc    (presc),
        .count    (count),
        .dir      (dir),
        .tc       (tc),
        .wrap     (wrap),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check count, dir, tc and wrap together after one edge.
    task automatic expect_state(input string tag, input int c, input bit d, input bit t, input bit w);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".dir"},   32'(dir),   32'(d));
        check({tag, ".tc"},    32'(tc),    32'(t));
        check({tag, ".wrap"},  32'(wrap),  32'(w));
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        mode     = 2'b00;
        sat      = 1'b0;
        cfg_min  = 4'd2;
        cfg_max  = 4'd11;
        presc    = '0;

        // Reset state
        tick();
        tick();
        expect_state("reset", 0, 0, 0, 0);
        check("reset.err", 32'(err), 32'd0);

        // 1. Up-wrap over 2..11
        reset = 1'b0;
        en    = 1'b1;
        tick();
        expect_state("up.recover", 2, 0, 0, 1);
        for (int v = 3; v <= 11; v++) begin
            tick();
            expect_state($sformatf("up.%0d", v), v, 0, (v == 11), 0);
        end
        tick();
        expect_state("up.wrap", 2, 0, 0, 1);

        // 2. Down-saturate over 3..9 from a load of 5
        cfg_min  = 4'd3;
        cfg_max  = 4'd9;
        mode     = 2'b01;
        sat      = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        tick();
        expect_state("dn.load", 5, 0, 0, 0);
        load = 1'b0;
        tick();
        expect_state("dn.4", 4, 1, 0, 0);
        tick();
        expect_state("dn.3", 3, 1, 1, 0);
        tick();
        expect_state("dn.hold1", 3, 1, 1, 1);
        tick();
        expect_state("dn.hold2", 3, 1, 1, 1);

        // 3. Bounce over 1..4 from a clear (count 1, dir up)
        cfg_min = 4'd1;
        cfg_max = 4'd4;
        mode    = 2'b10;
        clear   = 1'b1;
        tick();
        expect_state("bn.clear", 1, 0, 0, 0);
        clear = 1'b0;
        tick();
        expect_state("bn.2", 2, 0, 0, 0);
        tick();
        expect_state("bn.3", 3, 0, 0, 0);
        tick();
        expect_state("bn.4", 4, 0, 1, 0);
        tick();
        expect_state("bn.turn_hi", 3, 1, 0, 1);
        tick();
        expect_state("bn.2d", 2, 1, 0, 0);
        tick();
        expect_state("bn.1", 1, 1, 1, 0);
        tick();
        expect_state("bn.turn_lo", 2, 0, 0, 1);

        // 4. Prescale by 3 over 0..15, with en frozen for two cycles
        cfg_min = 4'd0;
        cfg_max = 4'd15;
        mode    = 2'b00;
        sat     = 1'b0;
        presc   = 4'd2;
        clear   = 1'b1;
        tick();
        check("ps.clear", 32'(count), 32'd0);
        clear = 1'b0;
        tick();
        check("ps.c1", 32'(count), 32'd0);
        tick();
        check("ps.c2", 32'(count), 32'd0);
        tick();
        check("ps.c3", 32'(count), 32'd1);
        tick();
        check("ps.c4", 32'(count), 32'd1);
        tick();
        check("ps.c5", 32'(count), 32'd1);
        en = 1'b0;
        tick();
        check("ps.frz1", 32'(count), 32'd1);
        tick();
        check("ps.frz2", 32'(count), 32'd1);
        en = 1'b1;
        // pcnt was held at its compare value, so the very next cycle steps.
        tick();
        check("ps.resume", 32'(count), 32'd2);

        // 5a. Out-of-range load, then step up recovers to cfg_min
        cfg_max  = 4'd9;
        presc    = 4'd0;
        load     = 1'b1;
        load_val = 4'd13;
        tick();
        expect_state("pr.load13", 13, 0, 0, 0);
        load = 1'b0;
        tick();
        expect_state("pr.recover", 0, 0, 0, 1);

        // 5b. Clear wins over load in the same cycle
        cfg_min  = 4'd4;
        clear    = 1'b1;
        load     = 1'b1;
        load_val = 4'd8;
        tick();
        check("pr.clr_ld", 32'(count), 32'd4);
        clear = 1'b0;
        load  = 1'b0;

        // 5c. Inverted window raises err and freezes stepping; load still acts
        en      = 1'b0;
        cfg_min = 4'd7;
        cfg_max = 4'd3;
        tick();
        check("pr.err", 32'(err), 32'd1);
        en = 1'b1;
        tick();
        check("pr.frz1", 32'(count), 32'd4);
        tick();
        check("pr.frz2", 32'(count), 32'd4);
        check("pr.err2", 32'(err), 32'd1);
        load     = 1'b1;
        load_val = 4'd6;
        tick();
        check("pr.err_load", 32'(count), 32'd6);
        load    = 1'b0;
        en      = 1'b0;
        cfg_min = 4'd0;
        cfg_max = 4'd15;
        tick();
        check("pr.err_clr", 32'(err), 32'd0);

        // 6. Reset at count 6 with pcnt 1
        en       = 1'b1;
        mode     = 2'b01;
        presc    = 4'd0;
        load     = 1'b1;
        load_val = 4'd7;
        tick();
        load = 1'b0;
        tick();
        expect_state("rs.pre6", 6, 1, 0, 0);
        presc = 4'd2;
        tick();
        check("rs.hold6", 32'(count), 32'd6);
        reset = 1'b1;
        tick();
        expect_state("rs.reset", 0, 0, 0, 0);
        check("rs.err", 32'(err), 32'd0);
        reset = 1'b0;
        mode  = 2'b00;
        tick();
        check("rs.s1", 32'(count), 32'd0);
        tick();
        check("rs.s2", 32'(count), 32'd0);
        tick();
        expect_state("rs.s3", 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the 4-bit load/mode counter.
- Counts within a run-time programmable window [cfg_min, cfg_max] with prescaled stepping.
- Supports up, down, bounce (up/down ping-pong) and hold modes, each with selectable wrap or saturate at the window edges.
- Used as a timebase and sequence counter by bridge control logic, with terminal-count and wrap event pulses.

Parameters:
- WIDTH, 4, counter and bound width in bits (WIDTH >= 2).
- PRESC_W, 4, prescaler width; one step occurs every presc+1 enabled cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; gates the prescaler and stepping.
- clear  input  1  synchronous clear of count to cfg_min.
- load  input  1  load load_val into count.
- load_val  input  WIDTH  value to load.
- mode  input  2  00 up, 01 down, 10 bounce, 11 hold.
- sat  input  1  1 = saturate at edges, 0 = wrap; ignored in bounce.
- cfg_min  input  WIDTH  lower bound, inclusive.
- cfg_max  input  WIDTH  upper bound, inclusive.
- presc  input  PRESC_W  prescale divisor minus one.
- count  output  WIDTH  current count, registered.
- dir  output  1  current direction (0 up, 1 down), registered.
- tc  output  1  one-cycle pulse when a step lands on the terminal value.
- wrap  output  1  one-cycle pulse on a wrap, saturate-block, bounce turn or out-of-range recovery.
- err  output  1  registered; high while cfg_min > cfg_max.

Behaviour:
- Reset values:
  - count = 0, dir = 0, tc = 0, wrap = 0, err = 0.
  - Internal prescaler pcnt = 0.
- Priority per cycle: reset > clear > load > step.
  - clear: count <= cfg_min, dir <= 0, pcnt <= 0.
  - load: count <= load_val unchanged, even if out of range; dir unchanged; pcnt <= 0.
- Prescaler:
  - Runs only when en=1, mode != 11 and err=0.
  - If pcnt == presc: step fires this cycle and pcnt <= 0; else pcnt <= pcnt+1.
  - presc = 0 means a step every enabled cycle.
  - A change to presc takes effect on the next compare; no pcnt reset.
- err:
  - err <= (cfg_min > cfg_max) every cycle.
  - While err=1, steps are suppressed; clear and load still act.
- Step, up (dir forced 0):
  - count < cfg_max: count+1.
  - count == cfg_max: wrap mode goes to cfg_min; sat mode holds cfg_max. wrap pulses in both cases.
- Step, down (dir forced 1):
  - Mirror of up: count-1; at cfg_min, wrap to cfg_max or hold, with wrap pulse.
- Step, bounce:
  - dir=0 and count == cfg_max: dir <= 1, count <= cfg_max-1, wrap pulses.
  - dir=1 and count == cfg_min: dir <= 0, count <= cfg_min+1, wrap pulses.
  - Otherwise step in dir.
  - cfg_min == cfg_max: count holds and wrap pulses each step.
- Out-of-range (count < cfg_min or count > cfg_max) at a step, no arithmetic, wrap pulses:
  - Up: count <= cfg_min.
  - Down: count <= cfg_max.
  - Bounce: count <= cfg_min, dir <= 0.
- tc:
  - Asserted in the cycle the new count is registered, when the step result equals the terminal value.
  - Terminal value: cfg_max for up and for bounce with dir=0; cfg_min for down and for bounce with dir=1.
  - Recomputed every step, so it is also asserted on each saturated hold.
  - Never asserted by load or clear.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Bound checks use full-width compares, so no overflow past 2^WIDTH-1 occurs.
- Mode change mid-count:
  - Takes effect on the next step.
  - Entering up or down overwrites dir; entering bounce keeps the current dir.
- Reset mid-prescale discards pcnt.

Test Plan:
1. Up-wrap: reset, cfg 2..11, mode 00, sat 0, presc 0, en 1. Sequence 0 -> 2 (wrap pulse), 3 ... 11 (tc), then 2 (wrap).
2. Down-saturate: load 5, cfg 3..9, mode 01, sat 1. Sequence 4, 3 (tc), then 3 held with wrap and tc every cycle.
3. Bounce: cfg 1..4, mode 10 from count 1. Sequence 2, 3, 4 (tc), 3 (dir=1, wrap), 2, 1 (tc), 2 (dir=0, wrap).
4. Prescale: presc 2, mode up, cfg 0..15. count increments once every 3 cycles; toggling en low for 2 cycles freezes both count and pcnt.
5. Priority/boundary:
   - load 13 with cfg 0..9, then step up: count 0 with wrap pulse.
   - Same-cycle clear+load: count = cfg_min.
   - cfg_min=7, cfg_max=3: err=1 next cycle and count frozen.
6. Reset mid-operation: assert reset at count 6 with pcnt 1. Next cycle count 0, dir 0, tc 0, wrap 0; first step after release occurs presc+1 cycles later.
